cnu_iter_ctrl_fsm: RTL and testbench



---
 rtl/cnu_iter_ctrl_fsm.sv | 147 ++++++++++++++
 tb/tb_cnu_iter_ctrl_fsm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnu_iter_ctrl_fsm.sv
// rtl/cnu_iter_ctrl_fsm.sv - decode-run iteration controller ahead of the CNU write-update handshake
module cnu_iter_ctrl_fsm #(
    parameter int ITER_MAX   = 10,
    parameter int ITER_WIDTH = 4,
    parameter int RD_DEPTH   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  read_clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  early_term_i,
    input  logic                  init_load_i,
    input  logic                  pipe_load_i,
    input  logic                  cnu_wr_i,
    output logic                  cnu_init_load_en_o,
    output logic                  cnu_rd_finish_o,
    output logic                  iter_update_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [ITER_WIDTH-1:0] iter_cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  early_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT_LOAD = 3'd1,
        READ      = 3'd2,
        RD_FIN    = 3'd3,
        WR_WAIT   = 3'd4,
        ITER_UP   = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(RD_DEPTH - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(ITER_MAX - 1);

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   rd_addr, rd_addr_nx;
    logic [ITER_WIDTH-1:0]   iter_cnt, iter_cnt_nx;
    logic                    early, early_nx;

    always_comb begin
        state_nx    = state;
        rd_addr_nx  = rd_addr;
        iter_cnt_nx = iter_cnt;
        early_nx    = early;
        if (stop_i) begin
            // abort wins over everything, including a same-cycle start in IDLE
            state_nx    = IDLE;
            rd_addr_nx  = '0;
            iter_cnt_nx = '0;
            if (state != IDLE) begin
                early_nx = 1'b0;
            end
        end else begin
            if (early_term_i && (state == READ || state == RD_FIN ||
                                 state == WR_WAIT || state == ITER_UP)) begin
                early_nx = 1'b1;
            end
            case (state)
                IDLE: begin
                    rd_addr_nx  = '0;
                    iter_cnt_nx = '0;
                    if (start_i) begin
                        state_nx = INIT_LOAD;
                        early_nx = 1'b0;
                    end
                end
                INIT_LOAD: begin
                    if (init_load_i) begin
                        state_nx   = READ;
                        rd_addr_nx = '0;
                    end
                end
                READ: begin
                    if (rd_addr == ADDR_LAST) begin
                        state_nx   = RD_FIN;
                        rd_addr_nx = '0;
                    end else begin
                        rd_addr_nx = rd_addr + ADDR_WIDTH'(1);
                    end
                end
                RD_FIN: begin
                    if (pipe_load_i) begin
                        state_nx = WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (cnu_wr_i) begin
                        state_nx = ITER_UP;
                    end
                end
                ITER_UP: begin
                    if (early || iter_cnt == ITER_LAST) begin
                        state_nx = DONE;
                    end else begin
                        iter_cnt_nx = iter_cnt + ITER_WIDTH'(1);
                        state_nx    = READ;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx    = IDLE;
                    rd_addr_nx  = '0;
                    iter_cnt_nx = '0;
                end
            endcase
        end
    end

    // outputs are registered off the next state so they line up with the state register
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state              <= IDLE;
            rd_addr            <= '0;
            iter_cnt           <= '0;
            early              <= 1'b0;
            cnu_init_load_en_o <= 1'b0;
            cnu_rd_finish_o    <= 1'b0;
            iter_update_o      <= 1'b0;
            rd_en_o            <= 1'b0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
        end else begin
            state              <= state_nx;
            rd_addr            <= rd_addr_nx;
            iter_cnt           <= iter_cnt_nx;
            early              <= early_nx;
            cnu_init_load_en_o <= (state_nx == INIT_LOAD);
            cnu_rd_finish_o    <= (state_nx == RD_FIN);
            iter_update_o      <= (state_nx == ITER_UP);
            rd_en_o            <= (state_nx == READ);
            busy_o             <= (state_nx != IDLE);
            done_o             <= (state_nx == DONE);
        end
    end

    assign rd_addr_o  = rd_addr;
    assign iter_cnt_o = iter_cnt;
    assign early_o    = early;

endmodule

// File: tb/tb_cnu_iter_ctrl_fsm.sv
// tb/tb_cnu_iter_ctrl_fsm.sv - directed self-checking bench for cnu_iter_ctrl_fsm
module tb_cnu_iter_ctrl_fsm;

    logic       read_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       early_term_i = 1'b0;
    logic       init_load_i = 1'b0;
    logic       pipe_load_i = 1'b0;
    logic       cnu_wr_i = 1'b0;
    logic       cnu_init_load_en_o;
    logic       cnu_rd_finish_o;
    logic       iter_update_o;
    logic       rd_en_o;
    logic [1:0] rd_addr_o;
    logic [1:0] iter_cnt_o;
    logic       busy_o;
    logic       done_o;
    logic       early_o;

    int total = 0;
    int bad = 0;

    cnu_iter_ctrl_fsm #(
        .ITER_MAX   (3),
        .ITER_WIDTH (2),
        .RD_DEPTH   (4),
        .ADDR_WIDTH (2)
    ) dut (
        .read_clk           (read_clk),
        .rstn               (rstn),
        .start_i            (start_i),
        .stop_i             (stop_i),
        .early_term_i       (early_term_i),
        .init_load_i        (init_load_i),
        .pipe_load_i        (pipe_load_i),
        .cnu_wr_i           (cnu_wr_i),
        .cnu_init_load_en_o (cnu_init_load_en_o),
        .cnu_rd_finish_o    (cnu_rd_finish_o),
        .iter_update_o      (iter_update_o),
        .rd_en_o            (rd_en_o),
        .rd_addr_o          (rd_addr_o),
        .iter_cnt_o         (iter_cnt_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .early_o            (early_o)
    );

    always #5 read_clk = ~read_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge read_clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_outs"}, 32'({cnu_init_load_en_o, cnu_rd_finish_o, iter_update_o, rd_en_o,
                                 busy_o, done_o, early_o}), 32'd0);
        chk({tag, "_addr"}, 32'(rd_addr_o), 32'd0);
        chk({tag, "_iter"}, 32'(iter_cnt_o), 32'd0);
    endtask

    task automatic begin_run();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_init_en", 32'(cnu_init_load_en_o), 32'd1);
        chk("start_early_clr", 32'(early_o), 32'd0);
        init_load_i = 1'b1;
        step();
        init_load_i = 1'b0;
        chk("init_done_en", 32'(cnu_init_load_en_o), 32'd0);
    endtask

    task automatic read_sweep(input int it, input bit pulse_early);
        for (int a = 0; a < 4; a++) begin
            chk("rd_en", 32'(rd_en_o), 32'd1);
            chk("rd_addr", 32'(rd_addr_o), 32'(a));
            chk("rd_iter", 32'(iter_cnt_o), 32'(it));
            early_term_i = pulse_early && (a == 1);
            step();
        end
        early_term_i = 1'b0;
    endtask

    task automatic finish_iter();
        chk("fin_flag", 32'(cnu_rd_finish_o), 32'd1);
        chk("fin_rd_en", 32'(rd_en_o), 32'd0);
        pipe_load_i = 1'b1;
        step();
        pipe_load_i = 1'b0;
        chk("wr_fin_low", 32'(cnu_rd_finish_o), 32'd0);
        chk("wr_no_upd", 32'(iter_update_o), 32'd0);
        cnu_wr_i = 1'b1;
        step();
        cnu_wr_i = 1'b0;
        chk("upd_pulse", 32'(iter_update_o), 32'd1);
    endtask

    initial begin
        int upd_seen;

        #2;
        all_zero("rst");
        #10 rstn = 1'b1;
        step();
        step();
        chk("idle_busy", 32'(busy_o), 32'd0);

        // nominal run
        begin_run();
        upd_seen = 0;
        for (int it = 0; it < 3; it++) begin
            read_sweep(it, 1'b0);
            finish_iter();
            upd_seen += int'(iter_update_o);
            step();
            chk("upd_one_cycle", 32'(iter_update_o), 32'd0);
        end
        chk("upd_count", 32'(upd_seen), 32'd3);
        chk("nom_done", 32'(done_o), 32'd1);
        chk("nom_done_busy", 32'(busy_o), 32'd1);
        chk("nom_early", 32'(early_o), 32'd0);
        step();
        chk("nom_done_once", 32'(done_o), 32'd0);
        chk("nom_idle_busy", 32'(busy_o), 32'd0);

        // early termination in iteration 1
        begin_run();
        read_sweep(0, 1'b0);
        finish_iter();
        step();
        read_sweep(1, 1'b1);
        chk("early_set", 32'(early_o), 32'd1);
        finish_iter();
        step();
        chk("early_done", 32'(done_o), 32'd1);
        chk("early_iter", 32'(iter_cnt_o), 32'd1);
        step();
        chk("early_idle_busy", 32'(busy_o), 32'd0);
        step();
        chk("early_held", 32'(early_o), 32'd1);

        // back-pressure, then abort in WR_WAIT of iteration 2
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("bp_early_clr", 32'(early_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk("bp_init_hold", 32'(cnu_init_load_en_o), 32'd1);
            step();
        end
        init_load_i = 1'b1;
        step();
        init_load_i = 1'b0;
        read_sweep(0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_fin_hold", 32'(cnu_rd_finish_o), 32'd1);
            step();
        end
        pipe_load_i = 1'b1;
        step();
        pipe_load_i = 1'b0;
        chk("bp_wr_wait", 32'(cnu_rd_finish_o), 32'd0);
        upd_seen = 0;
        for (int i = 0; i < 7; i++) begin
            upd_seen += int'(iter_update_o);
            step();
        end
        chk("bp_no_upd", 32'(upd_seen), 32'd0);
        cnu_wr_i = 1'b1;
        step();
        cnu_wr_i = 1'b0;
        chk("bp_upd", 32'(iter_update_o), 32'd1);
        step();
        read_sweep(1, 1'b0);
        finish_iter();
        step();
        read_sweep(2, 1'b0);
        chk("ab_fin", 32'(cnu_rd_finish_o), 32'd1);
        pipe_load_i = 1'b1;
        step();
        pipe_load_i = 1'b0;
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("ab_busy", 32'(busy_o), 32'd0);
        chk("ab_done", 32'(done_o), 32'd0);
        chk("ab_iter", 32'(iter_cnt_o), 32'd0);
        chk("ab_addr", 32'(rd_addr_o), 32'd0);
        step();
        chk("ab_no_done", 32'(done_o), 32'd0);

        // start ignored while busy
        begin_run();
        step();
        chk("ign_addr1", 32'(rd_addr_o), 32'd1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("ign_addr2", 32'(rd_addr_o), 32'd2);
        chk("ign_rd_en", 32'(rd_en_o), 32'd1);
        chk("ign_init_en", 32'(cnu_init_load_en_o), 32'd0);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("ign_stop_busy", 32'(busy_o), 32'd0);

        // start and stop together in IDLE
        start_i = 1'b1;
        stop_i  = 1'b1;
        step();
        start_i = 1'b0;
        stop_i  = 1'b0;
        chk("ss_busy", 32'(busy_o), 32'd0);
        chk("ss_init_en", 32'(cnu_init_load_en_o), 32'd0);

        // asynchronous reset mid-READ
        begin_run();
        step();
        step();
        chk("mr_addr", 32'(rd_addr_o), 32'd2);
        #2 rstn = 1'b0;
        #1;
        all_zero("mr_rst");
        #3 rstn = 1'b1;
        step();
        step();
        step();
        chk("mr_idle_busy", 32'(busy_o), 32'd0);
        chk("mr_idle_init", 32'(cnu_init_load_en_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
